// File: rtl/sobel_fb_writer.sv
// Sobel frame-buffer writer: interior pixel stream to raster BRAM writes,
// optional border fill (SOBEL_FB_BORDER_EN), then a frame_done pulse.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   start_frame         arm for a new frame (IDLE only)
//   in_valid, in_data   interior RGB565 pixel stream
//   fb_wr_en/addr/data  BRAM write port (registered)
//   busy                not IDLE
//   frame_done          1-cycle pulse after final write
//   overrun             1-cycle pulse: pixel dropped outside STREAM
module sobel_fb_writer #(
  parameter int          WIDTH        = 320,
  parameter int          HEIGHT       = 240,
  parameter int          ADDR_W       = 17,
  parameter logic [15:0] BORDER_VALUE = 16'h0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_frame,
  input  logic              in_valid,
  input  logic [15:0]       in_data,
  output logic              fb_wr_en,
  output logic [ADDR_W-1:0] fb_wr_addr,
  output logic [15:0]       fb_wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic              overrun
);

  localparam logic [8:0] X_LAST = 9'(WIDTH - 2);
  localparam logic [8:0] Y_LAST = 9'(HEIGHT - 2);
  localparam logic [ADDR_W-1:0] W_A = ADDR_W'(WIDTH);

`ifdef SOBEL_FB_BORDER_EN
  localparam logic [8:0] X_END = 9'(WIDTH - 1);
  localparam logic [ADDR_W-1:0] R_OFS = ADDR_W'(WIDTH - 1);
  localparam logic [ADDR_W-1:0] BOT_BASE =
    ADDR_W'((HEIGHT - 1) * WIDTH);

  typedef enum logic [1:0] {
    S_IDLE, S_STREAM, S_BORDER, S_DONE
  } state_t;

  typedef enum logic [1:0] {
    P_TOP, P_BOT, P_LEFT, P_RIGHT
  } phase_t;

  phase_t            b_phase;
  logic [ADDR_W-1:0] b_addr;
  logic              b_last;
`else
  typedef enum logic [1:0] {
    S_IDLE, S_STREAM, S_DONE
  } state_t;
`endif

  state_t            state;
  state_t            state_nxt;
  logic [8:0]        x;
  logic [8:0]        y;
  logic [ADDR_W-1:0] row_base;
  logic              last_px;

  assign last_px = in_valid && (state == S_STREAM)
                && (x == X_LAST) && (y == Y_LAST);

`ifdef SOBEL_FB_BORDER_EN
  assign b_last = (state == S_BORDER) && (b_phase == P_RIGHT)
               && (y == Y_LAST);
`endif

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (start_frame) state_nxt = S_STREAM;
`ifdef SOBEL_FB_BORDER_EN
      S_STREAM: if (last_px) state_nxt = S_BORDER;
      S_BORDER: if (b_last) state_nxt = S_DONE;
`else
      S_STREAM: if (last_px) state_nxt = S_DONE;
`endif
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb_wr_en   <= 1'b0;
      fb_wr_addr <= '0;
      fb_wr_data <= '0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      x          <= '0;
      y          <= '0;
      row_base   <= '0;
`ifdef SOBEL_FB_BORDER_EN
      b_phase    <= P_TOP;
      b_addr     <= '0;
`endif
    end else begin
      fb_wr_en   <= 1'b0;
      overrun    <= in_valid && (state != S_STREAM);
      frame_done <= (state == S_DONE);
      unique case (state)
        S_IDLE: begin
          if (start_frame) begin
            x        <= 9'd1;
            y        <= 9'd1;
            row_base <= W_A;
          end
        end
        S_STREAM: begin
          if (in_valid) begin
            fb_wr_en   <= 1'b1;
            fb_wr_addr <= row_base + ADDR_W'(x);
            fb_wr_data <= in_data;
            if (x == X_LAST) begin
              x        <= 9'd1;
              y        <= y + 9'd1;
              row_base <= row_base + W_A;
            end else begin
              x <= x + 9'd1;
            end
          end
`ifdef SOBEL_FB_BORDER_EN
          // x walks the top/bottom rows, y the side columns.
          if (last_px) begin
            b_phase <= P_TOP;
            b_addr  <= '0;
            x       <= '0;
            y       <= 9'd1;
          end
`endif
        end
`ifdef SOBEL_FB_BORDER_EN
        S_BORDER: begin
          fb_wr_en   <= 1'b1;
          fb_wr_addr <= b_addr;
          fb_wr_data <= BORDER_VALUE;
          unique case (b_phase)
            P_TOP: begin
              if (x == X_END) begin
                b_phase <= P_BOT;
                b_addr  <= BOT_BASE;
                x       <= '0;
              end else begin
                b_addr <= b_addr + 1'b1;
                x      <= x + 9'd1;
              end
            end
            P_BOT: begin
              if (x == X_END) begin
                b_phase <= P_LEFT;
                b_addr  <= W_A;
              end else begin
                b_addr <= b_addr + 1'b1;
                x      <= x + 9'd1;
              end
            end
            P_LEFT: begin
              b_phase <= P_RIGHT;
              b_addr  <= b_addr + R_OFS;
            end
            P_RIGHT: begin
              b_phase <= P_LEFT;
              b_addr  <= b_addr + 1'b1;
              y       <= y + 9'd1;
            end
            default: b_phase <= P_TOP;
          endcase
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sobel_fb_writer.sv
// Scoreboard bench for sobel_fb_writer at an 8x6 frame.
// Works with or without SOBEL_FB_BORDER_EN.
module tb_sobel_fb_writer;

  localparam int          W  = 8;
  localparam int          H  = 6;
  localparam logic [15:0] BV = 16'h07E0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_frame = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        fb_wr_en;
  logic [16:0] fb_wr_addr;
  logic [15:0] fb_wr_data;
  logic        busy;
  logic        frame_done;
  logic        overrun;

  sobel_fb_writer #(
    .WIDTH(W), .HEIGHT(H), .ADDR_W(17), .BORDER_VALUE(BV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_frame(start_frame),
    .in_valid(in_valid), .in_data(in_data),
    .fb_wr_en(fb_wr_en), .fb_wr_addr(fb_wr_addr),
    .fb_wr_data(fb_wr_data), .busy(busy),
    .frame_done(frame_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [16:0] a;
    logic [15:0] d;
  } wr_t;

  wr_t exp_q[$];
  wr_t e;
  int  vectors = 0;
  int  miscompares = 0;
  int  cyc = 0;
  int  last_wr = -10;
  int  done_cnt = 0;
  int  ovr_cnt = 0;
  int  zero_wr = 0;

  int int_addr[24] = '{
    9, 10, 11, 12, 13, 14,
    17, 18, 19, 20, 21, 22,
    25, 26, 27, 28, 29, 30,
    33, 34, 35, 36, 37, 38};

  int bord_addr[24] = '{
    0, 1, 2, 3, 4, 5, 6, 7,
    40, 41, 42, 43, 44, 45, 46, 47,
    8, 15, 16, 23, 24, 31, 32, 39};

  always @(posedge clk) cyc++;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (fb_wr_en) begin
      last_wr = cyc;
      if (fb_wr_addr == 17'd0) zero_wr++;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: addr %0d data %h, required none",
                 fb_wr_addr, fb_wr_data);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", 32'(fb_wr_addr), 32'(e.a));
        check("write_data", 32'(fb_wr_data), 32'(e.d));
      end
    end
    if (overrun) ovr_cnt++;
    if (frame_done) begin
      done_cnt++;
      check("done_after_last_write", cyc - last_wr, 1);
      check("done_queue_empty", exp_q.size(), 0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pixel(input int i);
    exp_q.push_back({17'(int_addr[i]), 16'(i)});
`ifdef SOBEL_FB_BORDER_EN
    if (i == 23)
      for (int k = 0; k < 24; k++)
        exp_q.push_back({17'(bord_addr[k]), BV});
`endif
    in_valid = 1'b1;
    in_data  = 16'(i);
    tick(1);
    in_valid = 1'b0;
    tick(2);
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 500) begin
      tick(1);
      n++;
    end
    check("frame_done_seen", done_cnt, target);
  endtask

  initial begin
    tick(2);
    check("rst_wr_en", 32'(fb_wr_en), 0);
    check("rst_addr", 32'(fb_wr_addr), 0);
    check("rst_data", 32'(fb_wr_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(frame_done), 0);
    check("rst_overrun", 32'(overrun), 0);
    rst_n = 1'b1;
    tick(1);

    in_valid = 1'b1;
    tick(1);
    in_valid = 1'b0;
    tick(2);
    check("overrun_idle", ovr_cnt, 1);
    check("idle_busy", 32'(busy), 0);

    start_frame = 1'b1;
    in_valid    = 1'b1;
    in_data     = 16'hFFFF;
    tick(1);
    start_frame = 1'b0;
    in_valid    = 1'b0;
    tick(2);
    check("overrun_start", ovr_cnt, 2);
    check("stream_busy", 32'(busy), 1);

    for (int i = 0; i < 24; i++) begin
      if (i == 12) begin
        start_frame = 1'b1;
        tick(1);
        start_frame = 1'b0;
      end
      pixel(i);
    end
    wait_done(1);
    tick(1);
    check("busy_after_done", 32'(busy), 0);
    check("overrun_total", ovr_cnt, 2);
`ifndef SOBEL_FB_BORDER_EN
    check("addr0_unwritten", zero_wr, 0);
`endif

    start_frame = 1'b1;
    tick(1);
    start_frame = 1'b0;
    for (int i = 0; i < 10; i++) pixel(i);
    tick(2);
    check("pre_reset_queue", exp_q.size(), 0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_wr_en", 32'(fb_wr_en), 0);
    check("midrst_addr", 32'(fb_wr_addr), 0);
    check("midrst_data", 32'(fb_wr_data), 0);
    check("midrst_busy", 32'(busy), 0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    start_frame = 1'b1;
    tick(1);
    start_frame = 1'b0;
    for (int i = 0; i < 24; i++) pixel(i);
    wait_done(2);
    tick(1);
    check("final_busy", 32'(busy), 0);
    check("final_queue", exp_q.size(), 0);
    check("final_overrun", ovr_cnt, 2);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
